mips_regfile_multiport: RTL
===========================

Name: mips_regfile_multiport

Overview:
Parametrised successor to the datapath register file. It supports a configurable data width, depth and number of read ports, and byte-enabled writes. It has an optional write-to-read bypass and a per-register pending-write scoreboard for hazard detection. It sits between decode (reads, reservations) and writeback (writes) in the MIPS datapath.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
NUM_REGS, 32, number of registers; power of two, at least 2.
ADDR_W, 5, address width; equals log2(NUM_REGS).
NUM_RD, 2, number of read ports, 1 to 4.
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return the stored value.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high; clears registers and scoreboard.
readAddress  input  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
outputData  output  NUM_RD*DATA_W  packed read data; port i is bits [i*DATA_W +: DATA_W].
outputBusy  output  NUM_RD  per read port: the addressed register has a pending write.
regWrite  input  1  write strobe.
writeAddress  input  ADDR_W  write target.
writeInputData  input  DATA_W  write data.
byteEnable  input  DATA_W/8  per-byte write mask.
reserve  input  1  marks reserveAddress as pending (load or long-latency op issued).
reserveAddress  input  ADDR_W  register to mark pending.
anyBusy  output  1  OR of all scoreboard bits.

Behaviour:
- Reset:
  - Synchronous, active-high. One rising edge with reset=1 clears all registers to 0 and all scoreboard bits to 0.
  - Reset overrides regWrite and reserve in the same cycle.
  - Reset asserted mid-sequence discards all pending reservations.
- Outputs after reset:
  - outputData = 0, outputBusy = 0, anyBusy = 0.
  - Read outputs are combinational from current state and inputs.
- Register 0:
  - Hardwired to 0. Writes to address 0 are ignored and reservations of address 0 are ignored.
  - Reads of address 0 always return 0 with busy=0, including under bypass.
- Write:
  - On a rising edge with regWrite=1 and writeAddress!=0, byte b of the register takes writeInputData byte b where byteEnable[b]=1; other bytes keep their value.
  - byteEnable all zero means no data change, but the scoreboard is still cleared.
  - Write latency is one cycle: with BYPASS=0 a read sees the new value starting the cycle after the write edge.
- Bypass (BYPASS=1):
  - Applies when regWrite=1, writeAddress!=0 and readAddress_i==writeAddress.
  - outputData_i = byte-merge of writeInputData into the stored value, per byteEnable, in the same cycle.
  - outputBusy_i = 0 in that case, unless reserve targets the same address in the same cycle.
- Scoreboard, one bit per register:
  - Set on an edge with reserve=1 and reserveAddress!=0.
  - Cleared on an edge with regWrite=1 to that address.
  - Simultaneous reserve and write to the same address: the bit ends set (the new reservation wins); the data write still occurs.
  - Reserving an already-busy register keeps it busy; there is no counting. One write clears it.
  - outputBusy_i = scoreboard[readAddress_i], subject to the bypass rule above.
- Multiple read ports:
  - Fully independent; any ports may read the same address.
- Address range:
  - Out-of-range addresses cannot occur because ADDR_W = log2(NUM_REGS).
- No X propagation:
  - All storage is initialised by reset; behaviour before the first reset is undefined.

Test Plan:
1. Reset, then all ports read addresses 0..31 -> every outputData=0, outputBusy=0, anyBusy=0.
2. Write 0xDEADBEEF to r5 with byteEnable=1111; next cycle read r5 on both ports -> 0xDEADBEEF on both. Write r0=55 -> r0 still reads 0.
3. r7=0x11223344, then write 0xAABBCCDD with byteEnable=0101 -> r7 reads 0x11BB33DD.
4. BYPASS=1: same cycle regWrite r9=0x55 while port 1 reads r9 (previously 0) -> outputData port 1 = 0x55 that cycle. BYPASS=0 build -> 0 that cycle, 0x55 the next.
5. Reserve r3 -> next cycle outputBusy=1 for r3 and anyBusy=1. Write r3 -> next cycle busy=0, anyBusy=0. Reserve and write r3 in the same cycle -> busy stays 1.
6. With r4=0x99 written and r6 reserved, assert reset for one edge -> r4 reads 0, r6 busy=0, anyBusy=0. A write issued in the reset cycle is discarded.

Source files
------------

// File: rtl/mips_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_multiport
// Brief    : Parametrised MIPS register file with NUM_RD read ports,
//            byte-enabled writes, optional same-cycle write-to-read bypass
//            and a per-register pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_RD*ADDR_W-1:0]  readAddress,
    output logic [NUM_RD*DATA_W-1:0]  outputData,
    output logic [NUM_RD-1:0]         outputBusy,
    input  logic                      regWrite,
    input  logic [ADDR_W-1:0]         writeAddress,
    input  logic [DATA_W-1:0]         writeInputData,
    input  logic [DATA_W/8-1:0]       byteEnable,
    input  logic                      reserve,
    input  logic [ADDR_W-1:0]         reserveAddress,
    output logic                      anyBusy
);

    localparam int c_NUM_BYTES = DATA_W / 8;

    logic [DATA_W-1:0]   r_regs [0:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_busy;

    logic                w_wr_en;
    logic                w_rsv_en;
    logic [DATA_W-1:0]   w_wr_merged;

    // Register 0 is hardwired, so writes and reservations aimed at it are dropped here.
    assign w_wr_en  = regWrite && (writeAddress != '0);
    assign w_rsv_en = reserve && (reserveAddress != '0);

    // Byte-merge of the incoming write into the currently stored word; shared by
    // the storage update and the bypass path since both target writeAddress.
    always_comb begin
        w_wr_merged = r_regs[writeAddress];
        for (int b = 0; b < c_NUM_BYTES; b++) begin
            if (byteEnable[b]) begin
                w_wr_merged[b*8 +: 8] = writeInputData[b*8 +: 8];
            end
        end
    end

    // Register storage: cleared on reset, otherwise updated by the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writeAddress] <= w_wr_merged;
        end
    end

    // Scoreboard: a write clears the bit, a reservation sets it; the
    // reservation is assigned last so it wins when both hit the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_busy[writeAddress] <= 1'b0;
            end
            if (w_rsv_en) begin
                r_busy[reserveAddress] <= 1'b1;
            end
        end
    end

    assign anyBusy = |r_busy;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = readAddress[gi*ADDR_W +: ADDR_W];
        assign w_hit  = (BYPASS != 0) && w_wr_en && (writeAddress == w_addr);

        // Per-port read: register 0 forced to zero, bypass hit forwards the
        // merged write word, otherwise the stored value and scoreboard bit.
        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_busy[w_addr];
            if (w_addr == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end else if (w_hit) begin
                w_data = w_wr_merged;
                w_busy = w_rsv_en && (reserveAddress == w_addr);
            end
        end

        assign outputData[gi*DATA_W +: DATA_W] = w_data;
        assign outputBusy[gi]                  = w_busy;
    end

endmodule
`default_nettype wire
